// File: rtl/controlador_conversao_bases_pkg.sv
// Shared definitions for the base-conversion front-end of the HEX0..HEX2
// display path: base codes, FSM state encoding, double-dabble step count
// and the leading-zero blanking rule.
package pkg_conversor;

  localparam logic [1:0] BASE_DEC = 2'b00;
  localparam logic [1:0] BASE_HEX = 2'b01;
  localparam logic [1:0] BASE_OCT = 2'b10;
  localparam logic [1:0] BASE_INV = 2'b11;

  localparam int unsigned N_PASSOS = 8;

  typedef enum logic [1:0] {
    OCIOSO      = 2'b00,
    CONVERTENDO = 2'b01,
    CONCLUIR    = 2'b10
  } estado_t;

  // Units are never blanked; tens only when hundreds are blank too.
  // Hex always has centena = 0, so the same rule blanks it.
  function automatic logic [2:0] calc_apagar(input logic [3:0] centena,
                                             input logic [3:0] dezena);
    logic [2:0] flags;
    flags[2] = (centena == 4'd0);
    flags[1] = (centena == 4'd0) && (dezena == 4'd0);
    flags[0] = 1'b0;
    return flags;
  endfunction

endpackage

// File: rtl/controlador_conversao_bases_passo_double_dabble.sv
// One combinational double-dabble step: add 3 to every BCD nibble >= 5,
// then shift the 12-bit accumulator left by one, inserting bit_i.
// Ports:
//   bcd_i  [11:0]  current BCD accumulator (hundreds/tens/units)
//   bit_i          next binary bit, MSB first
//   bcd_o  [11:0]  accumulator after add-3-and-shift
module passo_double_dabble (
  input  logic [11:0] bcd_i,
  input  logic        bit_i,
  output logic [11:0] bcd_o
);

  logic [11:0] ajustado;

  always_comb begin
    ajustado = bcd_i;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        ajustado[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
    bcd_o = {ajustado[10:0], bit_i};
  end

endmodule

// File: rtl/controlador_conversao_bases.sv
// Sequential base converter feeding the 7-segment decoders. Captures an
// 8-bit value on request and presents centena/dezena/unidade digits with
// leading-zero blank flags. Decimal runs an 8-step double-dabble; hex and
// octal complete in one edge.
// Optional macro CONVERSAO_AUTO_EN: free-running DIV_CICLO-cycle refresh tick
// that acts as an extra conversion request (held pending outside OCIOSO).
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   iniciar              conversion request, sampled only in OCIOSO
//   valor_binario [7:0]  value to convert
//   base_selecionada[1:0] 00 dec, 01 hex, 10 oct, 11 invalid
//   ocupado              high while in CONVERTENDO
//   pronto               one-cycle pulse when digits were just updated
//   erro_base            one-cycle pulse on a rejected base-11 request
//   digito_centena/dezena/unidade [3:0]  presented digits
//   apagar [2:0]         blank flags {centena, dezena, unidade}
//   base_ativa [1:0]     base of the presented digits
module controlador_conversao_bases
  import pkg_conversor::*;
#(
  parameter int unsigned DIV_CICLO = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iniciar,
  input  logic [7:0] valor_binario,
  input  logic [1:0] base_selecionada,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro_base,
  output logic [3:0] digito_centena,
  output logic [3:0] digito_dezena,
  output logic [3:0] digito_unidade,
  output logic [2:0] apagar,
  output logic [1:0] base_ativa
);

  if (DIV_CICLO == 0) begin : g_div_invalido
    $error("DIV_CICLO must be at least 1");
  end

  estado_t     estado_q, estado_d;
  logic [7:0]  valor_q, valor_d;
  logic [11:0] bcd_q, bcd_d, bcd_prox;
  logic [2:0]  passo_q, passo_d;
  logic        erro_q, erro_d;
  logic [3:0]  cent_q, cent_d, dez_q, dez_d, uni_q, uni_d;
  logic [2:0]  apagar_q, apagar_d;
  logic [1:0]  base_q, base_d;
  logic        pedido;

`ifdef CONVERSAO_AUTO_EN
  logic [31:0] div_q;
  logic        pend_q;
  logic        tick;

  assign tick   = (div_q == 32'(DIV_CICLO - 1));
  assign pedido = iniciar | tick | pend_q;

  // A tick outside OCIOSO is remembered; any OCIOSO cycle consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      div_q  <= tick ? '0 : div_q + 32'd1;
      pend_q <= (estado_q == OCIOSO) ? 1'b0 : (pend_q | tick);
    end
  end
`else
  assign pedido = iniciar;
`endif

  passo_double_dabble u_passo (
    .bcd_i (bcd_q),
    .bit_i (valor_q[7]),
    .bcd_o (bcd_prox)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      valor_q  <= '0;
      bcd_q    <= '0;
      passo_q  <= '0;
      erro_q   <= 1'b0;
      cent_q   <= '0;
      dez_q    <= '0;
      uni_q    <= '0;
      apagar_q <= 3'b110;
      base_q   <= BASE_DEC;
    end else begin
      estado_q <= estado_d;
      valor_q  <= valor_d;
      bcd_q    <= bcd_d;
      passo_q  <= passo_d;
      erro_q   <= erro_d;
      cent_q   <= cent_d;
      dez_q    <= dez_d;
      uni_q    <= uni_d;
      apagar_q <= apagar_d;
      base_q   <= base_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    valor_d  = valor_q;
    bcd_d    = bcd_q;
    passo_d  = passo_q;
    erro_d   = 1'b0;
    cent_d   = cent_q;
    dez_d    = dez_q;
    uni_d    = uni_q;
    apagar_d = apagar_q;
    base_d   = base_q;

    case (estado_q)
      OCIOSO: begin
        if (pedido) begin
          case (base_selecionada)
            BASE_INV: erro_d = 1'b1;
            BASE_DEC: begin
              valor_d  = valor_binario;
              bcd_d    = '0;
              passo_d  = '0;
              estado_d = CONVERTENDO;
            end
            BASE_HEX: begin
              cent_d   = 4'd0;
              dez_d    = valor_binario[7:4];
              uni_d    = valor_binario[3:0];
              apagar_d = calc_apagar(4'd0, valor_binario[7:4]);
              base_d   = BASE_HEX;
              estado_d = CONCLUIR;
            end
            default: begin
              cent_d   = {2'b00, valor_binario[7:6]};
              dez_d    = {1'b0, valor_binario[5:3]};
              uni_d    = {1'b0, valor_binario[2:0]};
              apagar_d = calc_apagar({2'b00, valor_binario[7:6]},
                                     {1'b0, valor_binario[5:3]});
              base_d   = BASE_OCT;
              estado_d = CONCLUIR;
            end
          endcase
        end
      end
      CONVERTENDO: begin
        // valor_q shifts left so its MSB always feeds the next step.
        bcd_d   = bcd_prox;
        valor_d = {valor_q[6:0], 1'b0};
        passo_d = passo_q + 3'd1;
        if (passo_q == 3'(N_PASSOS - 1)) begin
          cent_d   = bcd_prox[11:8];
          dez_d    = bcd_prox[7:4];
          uni_d    = bcd_prox[3:0];
          apagar_d = calc_apagar(bcd_prox[11:8], bcd_prox[7:4]);
          base_d   = BASE_DEC;
          estado_d = CONCLUIR;
        end
      end
      CONCLUIR: estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  assign ocupado        = (estado_q == CONVERTENDO);
  assign pronto         = (estado_q == CONCLUIR);
  assign erro_base      = erro_q;
  assign digito_centena = cent_q;
  assign digito_dezena  = dez_q;
  assign digito_unidade = uni_q;
  assign apagar         = apagar_q;
  assign base_ativa     = base_q;

endmodule

// File: tb/tb_controlador_conversao_bases.sv
module tb_controlador_conversao_bases;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iniciar = 1'b0;
  logic [7:0] valor_binario = '0;
  logic [1:0] base_selecionada = '0;
  logic       ocupado, pronto, erro_base;
  logic [3:0] digito_centena, digito_dezena, digito_unidade;
  logic [2:0] apagar;
  logic [1:0] base_ativa;

  int total = 0;
  int bad   = 0;

  controlador_conversao_bases #(.DIV_CICLO(50000000)) dut (
    .clk              (clk),
    .rst              (rst),
    .iniciar          (iniciar),
    .valor_binario    (valor_binario),
    .base_selecionada (base_selecionada),
    .ocupado          (ocupado),
    .pronto           (pronto),
    .erro_base        (erro_base),
    .digito_centena   (digito_centena),
    .digito_dezena    (digito_dezena),
    .digito_unidade   (digito_unidade),
    .apagar           (apagar),
    .base_ativa       (base_ativa)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({ocupado, pronto, erro_base} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {ocupado, pronto, erro_base});
    end
    total++;
    if ({digito_centena, digito_dezena, digito_unidade, apagar, base_ativa} !== {12'h000, 3'b110, 2'b00}) begin
      bad++; $display("FAIL reset_outs got=%h/%b/%b exp=000/110/00",
                      {digito_centena, digito_dezena, digito_unidade}, apagar, base_ativa);
    end
  endtask

  task automatic test_decimal_255();
    int n_ocup = 0;
    int n_pronto = 0;
    valor_binario = 8'd255; base_selecionada = 2'b00; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ocupado === 1'b1) n_ocup++;
      if (pronto === 1'b1) n_pronto++;
      @(negedge clk);
    end
    total++;
    if (n_ocup != 8 || n_pronto != 0) begin
      bad++; $display("FAIL dec255_busy ocupado_cycles=%0d pronto_early=%0d exp=8/0", n_ocup, n_pronto);
    end
    total++;
    if ({ocupado, pronto} !== 2'b01) begin
      bad++; $display("FAIL dec255_pronto got ocupado/pronto=%b exp=01", {ocupado, pronto});
    end
    total++;
    if ({digito_centena, digito_dezena, digito_unidade, apagar, base_ativa} !== {12'h255, 3'b000, 2'b00}) begin
      bad++; $display("FAIL dec255_digits got=%h/%b/%b exp=255/000/00",
                      {digito_centena, digito_dezena, digito_unidade}, apagar, base_ativa);
    end
    @(negedge clk);
    total++;
    if (pronto !== 1'b0 || {digito_centena, digito_dezena, digito_unidade} !== 12'h255) begin
      bad++; $display("FAIL dec255_hold got pronto=%b digits=%h exp=0/255",
                      pronto, {digito_centena, digito_dezena, digito_unidade});
    end
  endtask

  task automatic test_hex();
    valor_binario = 8'hA7; base_selecionada = 2'b01; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    total++;
    if ({ocupado, pronto} !== 2'b01) begin
      bad++; $display("FAIL hex_pronto got ocupado/pronto=%b exp=01", {ocupado, pronto});
    end
    total++;
    if ({digito_centena, digito_dezena, digito_unidade, apagar, base_ativa} !== {12'h0A7, 3'b100, 2'b01}) begin
      bad++; $display("FAIL hex_digits got=%h/%b/%b exp=0a7/100/01",
                      {digito_centena, digito_dezena, digito_unidade}, apagar, base_ativa);
    end
    @(negedge clk);
  endtask

  task automatic test_octal();
    valor_binario = 8'd5; base_selecionada = 2'b10; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    total++;
    if ({pronto, digito_centena, digito_dezena, digito_unidade, apagar, base_ativa} !== {1'b1, 12'h005, 3'b110, 2'b10}) begin
      bad++; $display("FAIL oct5 got pronto=%b %h/%b/%b exp=1 005/110/10", pronto,
                      {digito_centena, digito_dezena, digito_unidade}, apagar, base_ativa);
    end
    @(negedge clk);
    valor_binario = 8'd255; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    total++;
    if ({pronto, digito_centena, digito_dezena, digito_unidade, apagar, base_ativa} !== {1'b1, 12'h377, 3'b000, 2'b10}) begin
      bad++; $display("FAIL oct255 got pronto=%b %h/%b/%b exp=1 377/000/10", pronto,
                      {digito_centena, digito_dezena, digito_unidade}, apagar, base_ativa);
    end
    @(negedge clk);
  endtask

  task automatic test_base_invalida();
    valor_binario = 8'h12; base_selecionada = 2'b11; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    total++;
    if ({erro_base, pronto, ocupado} !== 3'b100) begin
      bad++; $display("FAIL inv_pulse got erro/pronto/ocupado=%b exp=100", {erro_base, pronto, ocupado});
    end
    total++;
    if ({digito_centena, digito_dezena, digito_unidade, base_ativa} !== {12'h377, 2'b10}) begin
      bad++; $display("FAIL inv_hold got=%h/%b exp=377/10",
                      {digito_centena, digito_dezena, digito_unidade}, base_ativa);
    end
    @(negedge clk);
    total++;
    if ({erro_base, pronto} !== 2'b00) begin
      bad++; $display("FAIL inv_end got erro/pronto=%b exp=00", {erro_base, pronto});
    end
  endtask

  task automatic test_reset_meio();
    int n_pronto = 0;
    valor_binario = 8'd100; base_selecionada = 2'b00; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({ocupado, pronto, erro_base, digito_centena, digito_dezena, digito_unidade, apagar, base_ativa}
        !== {3'b000, 12'h000, 3'b110, 2'b00}) begin
      bad++; $display("FAIL midrst_outs got flags=%b %h/%b/%b exp=000 000/110/00",
                      {ocupado, pronto, erro_base}, {digito_centena, digito_dezena, digito_unidade},
                      apagar, base_ativa);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pronto === 1'b1) n_pronto++;
    end
    total++;
    if (n_pronto != 0) begin
      bad++; $display("FAIL midrst_no_pronto got pronto_cycles=%0d exp=0", n_pronto);
    end
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if ({pronto, digito_centena, digito_dezena, digito_unidade, apagar, base_ativa} !== {1'b1, 12'h100, 3'b000, 2'b00}) begin
      bad++; $display("FAIL midrst_redo got pronto=%b %h/%b/%b exp=1 100/000/00", pronto,
                      {digito_centena, digito_dezena, digito_unidade}, apagar, base_ativa);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    valor_binario = 8'd100; base_selecionada = 2'b00; iniciar = 1'b1;
    @(negedge clk);
    valor_binario = 8'd7; base_selecionada = 2'b01;
    repeat (8) @(negedge clk);
    total++;
    if ({pronto, digito_centena, digito_dezena, digito_unidade, base_ativa} !== {1'b1, 12'h100, 2'b00}) begin
      bad++; $display("FAIL b2b_first got pronto=%b %h/%b exp=1 100/00", pronto,
                      {digito_centena, digito_dezena, digito_unidade}, base_ativa);
    end
    @(negedge clk);
    total++;
    if ({ocupado, pronto} !== 2'b00) begin
      bad++; $display("FAIL b2b_idle got ocupado/pronto=%b exp=00", {ocupado, pronto});
    end
    @(negedge clk);
    iniciar = 1'b0;
    total++;
    if ({pronto, digito_centena, digito_dezena, digito_unidade, apagar, base_ativa} !== {1'b1, 12'h007, 3'b110, 2'b01}) begin
      bad++; $display("FAIL b2b_second got pronto=%b %h/%b/%b exp=1 007/110/01", pronto,
                      {digito_centena, digito_dezena, digito_unidade}, apagar, base_ativa);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_decimal_255();
    test_hex();
    test_octal();
    test_base_invalida();
    test_reset_meio();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
